alu16_pipe: RTL and testbench

- Two-stage pipelined 16-bit Hack ALU that directly consumes the bitwise-inversion stage.
- It applies the zx/nx/zy/ny operand conditioning (the nx/ny/no negations are the inverter function), then f (add/and) and no.
- It produces the result plus zr/ng flags.
- Valid/ready handshakes on both sides and full backpressure make it insertable between the register file and writeback.

---
 rtl/hack_alu_pkg.sv | 24 ++
 rtl/alu_cond16.sv | 19 +
 rtl/alu16_pipe.sv | 94 +++++++++
 tb/tb_alu16_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_alu_pkg.sv
// Shared control encoding for the pipelined Hack ALU.
// The control word is {zx,nx,zy,ny,f,no}, with zx in bit 5 and no in bit 0.
package hack_alu_pkg;

   localparam int unsigned CTRL_W = 6;

   localparam int unsigned ZX = 5;
   localparam int unsigned NX = 4;
   localparam int unsigned ZY = 3;
   localparam int unsigned NY = 2;
   localparam int unsigned F  = 1;
   localparam int unsigned NO = 0;

   // Field order follows the bit indices above, so a cast from the raw bus is direct.
   typedef struct packed {
      logic zx;
      logic nx;
      logic zy;
      logic ny;
      logic f;
      logic no;
   } alu_ctrl_t;

endpackage

// File: rtl/alu_cond16.sv
// Operand conditioning for one Hack ALU input.
// The operand is optionally zeroed, then optionally bitwise-inverted.
module alu_cond16 #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] a,
   input  logic         zero,
   input  logic         neg,
   output logic [W-1:0] res
);

   logic [W-1:0] zeroed;

   always_comb begin
      zeroed = zero ? '0 : a;
      res    = neg ? ~zeroed : zeroed;
   end

endmodule

// File: rtl/alu16_pipe.sv
// Two-stage Hack ALU with valid/ready on both sides and full backpressure.
// Stage 1 holds the conditioned operands; stage 2 holds the result and its flags.
module alu16_pipe
   import hack_alu_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W-1:0]      in_x,
   input  logic [W-1:0]      in_y,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic              out_zr,
   output logic              out_ng
);

   alu_ctrl_t    ctrl;
   logic [W-1:0] cond_x;
   logic [W-1:0] cond_y;

   logic         s1_valid;
   logic [W-1:0] s1_x;
   logic [W-1:0] s1_y;
   logic         s1_f;
   logic         s1_no;

   logic         adv2;
   logic         acc;
   logic [W-1:0] r;

   assign ctrl = alu_ctrl_t'(in_ctrl);

   alu_cond16 #(.W(W)) u_cond_x (
      .a    (in_x),
      .zero (ctrl.zx),
      .neg  (ctrl.nx),
      .res  (cond_x)
   );

   alu_cond16 #(.W(W)) u_cond_y (
      .a    (in_y),
      .zero (ctrl.zy),
      .neg  (ctrl.ny),
      .res  (cond_y)
   );

   // Handshake and stage-2 function; in_ready never looks at in_valid.
   always_comb begin
      adv2     = s1_valid && (!out_valid || out_ready);
      in_ready = !s1_valid || adv2;
      acc      = in_valid && in_ready;
      r        = s1_f ? (s1_x + s1_y) : (s1_x & s1_y);
      if (s1_no) begin
         r = ~r;
      end
   end

   // Output beat is only replaced when stage 1 advances, so it holds while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_x      <= '0;
         s1_y      <= '0;
         s1_f      <= 1'b0;
         s1_no     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_zr    <= 1'b0;
         out_ng    <= 1'b0;
      end else begin
         if (acc) begin
            s1_x  <= cond_x;
            s1_y  <= cond_y;
            s1_f  <= ctrl.f;
            s1_no <= ctrl.no;
         end
         s1_valid <= acc || (s1_valid && !adv2);
         if (adv2) begin
            out_valid <= 1'b1;
            out_data  <= r;
            out_zr    <= (r == '0);
            out_ng    <= r[W-1];
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu16_pipe.sv
// Self-checking bench for alu16_pipe: directed Hack ALU vectors, stall/reset cases,
// and a long random valid/ready run scored against an arithmetic reference model.
module tb_alu16_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_x;
   logic [15:0] in_y;
   logic [5:0]  in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_zr;
   logic        out_ng;

   int n_checks = 0;
   int n_fail   = 0;
   int n_in     = 0;
   int n_out    = 0;

   logic [17:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data  = '0;

   always #5 clk = ~clk;

   alu16_pipe #(.W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_zr    (out_zr),
      .out_ng    (out_ng)
   );

   // Reference Hack ALU in plain integer arithmetic; returns {zr, ng, data}.
   function automatic logic [17:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
      int unsigned a;
      int unsigned b;
      int unsigned r;
      logic [15:0] d;
      a = c[5] ? 0 : int'(x);
      if (c[4]) a = 65535 - a;
      b = c[3] ? 0 : int'(y);
      if (c[2]) b = 65535 - b;
      r = c[1] ? (a + b) % 65536 : (a & b);
      if (c[0]) r = 65535 - r;
      d = 16'(r);
      return {(r == 0), (r >= 32768), d};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: sampled on the falling edge, mid-cycle between DUT updates.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 32'd1, 32'd0);
            end else begin
               logic [17:0] e;
               e = exp_q.pop_front();
               check("sb_result", 32'({out_zr, out_ng, out_data}), 32'(e));
               n_out++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_alu(in_x, in_y, in_ctrl));
            n_in++;
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // Single beat into an idle pipe with out_ready high; pins exact latency and result.
   task automatic directed(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c,
                           input logic [15:0] d, input logic zr, input logic ng);
      check("model_pin", 32'(ref_alu(x, y, c)), 32'({zr, ng, d}));
      in_x = x; in_y = y; in_ctrl = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_ctrl  = 6'h3f;
      check("lat_not_yet", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_valid", 32'(out_valid), 32'd1);
      check("dir_data", 32'(out_data), 32'(d));
      check("dir_zr", 32'(out_zr), 32'(zr));
      check("dir_ng", 32'(out_ng), 32'(ng));
      @(posedge clk); #1;
      check("dir_drained", 32'(out_valid), 32'd0);
   endtask

   // Offer one beat and hold it until accepted, within a cycle budget.
   task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
      logic took;
      int   cyc;
      in_x = x; in_y = y; in_ctrl = c; in_valid = 1'b1;
      took = 1'b0;
      cyc  = 0;
      while (!took && cyc < 50) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      if (!took) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int cyc;
      out_ready = 1'b1;
      cyc = 0;
      while ((exp_q.size() != 0) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      @(posedge clk); #1;
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] held;
      logic        take;
      int          beats;
      int          cyc;

      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_ctrl = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_zr", 32'(out_zr), 32'd0);
      check("rst_out_ng", 32'(out_ng), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      directed(16'd5, 16'd3, 6'b000010, 16'h0008, 1'b0, 1'b0);
      directed(16'h1234, 16'habcd, 6'b101010, 16'h0000, 1'b1, 1'b0);
      directed(16'h1234, 16'habcd, 6'b111010, 16'hffff, 1'b0, 1'b1);
      directed(16'h00f0, 16'h5555, 6'b001101, 16'hff0f, 1'b0, 1'b1);
      directed(16'd5, 16'd3, 6'b010011, 16'h0002, 1'b0, 1'b0);
      directed(16'h7fff, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1);
      directed(16'hffff, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0);
      directed(16'hf0f0, 16'h3c3c, 6'b000000, 16'h3030, 1'b0, 1'b0);

      // Eight back-to-back beats: results must appear on eight consecutive cycles.
      for (int i = 0; i < 8; i++) begin
         in_x = 16'(i * 7); in_y = 16'(i + 100); in_ctrl = 6'b000010; in_valid = 1'b1;
         @(posedge clk); #1;
         if (i >= 1) check("b2b_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("b2b_last", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      check("b2b_done", 32'(out_valid), 32'd0);

      // Stall: two beats fit, the third is refused and the output holds.
      out_ready = 1'b0;
      push(16'h0011, 16'h0022, 6'b000010);
      push(16'h0100, 16'h0001, 6'b010011);
      in_x = 16'h4000; in_y = 16'h4000; in_ctrl = 6'b000010; in_valid = 1'b1;
      #1;
      held = out_data;
      check("stall_first", 32'(out_data), 32'h0033);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_hold", 32'(out_data), 32'(held));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(16'h4000, 16'h4000, 6'b000010);
      drain();

      // Reset with two beats in flight: nothing stale may ever emerge.
      out_ready = 1'b0;
      push(16'h0aaa, 16'h0555, 6'b000010);
      push(16'h0fff, 16'h0001, 6'b000010);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_data", 32'(out_data), 32'd0);
      out_ready = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("mid_rst_quiet", 32'(out_valid), 32'd0);
      end

      // Random valid/ready traffic; an offered beat stays stable until accepted.
      n_in = 0; n_out = 0;
      beats = 0; cyc = 0; take = 1'b0;
      in_valid = 1'b0;
      while (beats < 10000 && cyc < 60000) begin
         if (take || !in_valid) begin
            in_valid = ($urandom_range(3) != 0);
            in_x     = ($urandom_range(7) == 0) ? 16'h7fff : 16'($urandom);
            in_y     = ($urandom_range(7) == 0) ? 16'hffff : 16'($urandom);
            in_ctrl  = 6'($urandom);
         end
         out_ready = ($urandom_range(2) != 0);
         @(negedge clk);
         take = in_valid && in_ready;
         if (take) beats++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("rand_beats", 32'(beats), 32'd10000);
      drain();
      check("count_in_out", 32'(n_in), 32'(n_out));
      check("count_in", 32'(n_in), 32'd10000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
